srff_response_monitor: RTL

- Synthesizable observer and checker for an SR flip-flop under test. It sits at the receiving end of an SR stimulus stream.
- Samples the s/r/DUT-reset inputs driven into the flip-flop and the q it returns, and runs a cycle-accurate reference model alongside it.
- Counts mismatches and illegal s=r=1 events over a programmed window, then reports pass/fail through a start/done handshake.
- Used in FPGA self-test builds and as a bench-side scoreboard for the flip-flop family.

---
 rtl/srff_response_monitor.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/srff_response_monitor.sv
// srff_response_monitor: observer/checker for an SR flip-flop under test.
// Runs a cycle-accurate reference model beside the DUT, counts mismatches
// and illegal s=r=1 cycles over a programmed window, reports pass/fail.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high monitor reset
//   start, cfg_len      one-cycle window request and window length
//   mon_rst             synchronous reset as seen by the DUT
//   mon_s, mon_r        set / reset inputs as seen by the DUT
//   mon_q               DUT output q
//   busy, done, pass    window in progress, completion pulse, result
//   err_cnt             saturating mismatch count
//   illegal_cnt         saturating count of s=r=1 cycles
//
// Optional feature (macro SRFF_MON_FIRST_ERR_EN):
//   first_err_idx       zero-based index of the first mismatching compare
//   first_err_vld       first_err_idx holds a capture
module srff_response_monitor #(
    parameter int CNT_W          = 8,
    parameter bit DUT_RST_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             mon_rst,
    input  logic             mon_s,
    input  logic             mon_r,
    input  logic             mon_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] illegal_cnt
`ifdef SRFF_MON_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             q_exp;
    logic             exp_valid;

    logic             dut_rst;
    logic             illegal_in;
    logic             mismatch;
    logic             in_check;
    logic             last_edge;
    logic [CNT_W-1:0] err_nx;
    logic [CNT_W-1:0] ill_nx;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    assign dut_rst    = (mon_rst == DUT_RST_ACTIVE);
    assign illegal_in = mon_s & mon_r & ~dut_rst;

    // q_exp and mon_q both reflect the previous edge, so they line up
    // without extra delay.
    assign mismatch   = exp_valid & (mon_q != q_exp);
    assign in_check   = (state == CHECK);
    assign last_edge  = in_check & (cnt == CNT_ONE);

    // ------------------------------------------------------------------
    // Saturating counter next values
    // ------------------------------------------------------------------
    always_comb begin
        err_nx = err_cnt;
        if (in_check && mismatch && (err_cnt != CNT_MAX)) begin
            err_nx = err_cnt + CNT_ONE;
        end
    end

    always_comb begin
        ill_nx = illegal_cnt;
        if (in_check && illegal_in && (illegal_cnt != CNT_MAX)) begin
            ill_nx = illegal_cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: runs every edge, independent of the window FSM.
    // DUT reset has priority over s/r; s=r=1 leaves q undefined.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_exp     <= 1'b0;
            exp_valid <= 1'b0;
        end else if (dut_rst) begin
            q_exp     <= 1'b0;
            exp_valid <= 1'b1;
        end else begin
            unique case ({mon_s, mon_r})
                2'b01: begin
                    q_exp     <= 1'b0;
                    exp_valid <= 1'b1;
                end
                2'b10: begin
                    q_exp     <= 1'b1;
                    exp_valid <= 1'b1;
                end
                2'b11: begin
                    exp_valid <= 1'b0;
                end
                default: begin
                    q_exp     <= q_exp;
                    exp_valid <= exp_valid;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window FSM and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            illegal_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err_cnt     <= '0;
                        illegal_cnt <= '0;
                        cnt         <= cfg_len;
                        busy        <= 1'b1;
                        if (cfg_len == CNT_ZERO) begin
                            // Empty window: nothing to compare, so it passes.
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= CHECK;
                            pass  <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    err_cnt     <= err_nx;
                    illegal_cnt <= ill_nx;
                    cnt         <= cnt - CNT_ONE;
                    if (last_edge) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_nx == CNT_ZERO);
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRFF_MON_FIRST_ERR_EN
    // ------------------------------------------------------------------
    // First-error capture: index = compares already made in this window.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q         <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if ((state == IDLE) && start) begin
            len_q         <= cfg_len;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (in_check && mismatch && !first_err_vld) begin
            first_err_idx <= len_q - cnt;
            first_err_vld <= 1'b1;
        end
    end
`endif

endmodule
